// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
//   SRAM-like data bus between the M-stage access controller and the data
//   memory side.
//
// Signals:
//   data_req      master->slave  bus request
//   data_wr       master->slave  1 = write
//   data_size     master->slave  0 byte, 1 half, 2 word
//   data_addr     master->slave  bus address
//   data_wdata    master->slave  lane-replicated store data
//   data_wstrb    master->slave  byte strobes
//   data_addr_ok  slave->master  address accepted
//   data_data_ok  slave->master  read data valid / write complete
//   data_rdata    slave->master  raw read word
//
// Modports: master (controller side), slave (memory side).
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_wstrb;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   M-stage data-side access controller. Turns the EX/MEM load/store fields into
//   SRAM-like bus transactions, stalls the pipeline while a transaction is in
//   flight, drains transactions whose instruction was flushed, and returns the
//   aligned/extended load result plus address-error flags.
//
// Optional feature macro: UNALIGNED_LS_EN
//   defined   : ls_op 5/6 are MIPS LWL/LWR/SWL/SWR (word access at the aligned
//               address, merged load data / partial strobes).
//   undefined : ls_op 5/6 behave exactly as LW/SW (including alignment check).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_mem_read_en       M-stage load valid
//   i_mem_write_en      M-stage store valid
//   i_mem_addr          effective address
//   i_ls_op             0 B, 1 BU, 2 H, 3 HU, 4 W, 5 WL, 6 WR, 7 = W
//   i_wdata_in          rt value (store data, merge source for WL/WR)
//   i_flush             M instruction killed this cycle
//   i_stall_ext         stall from non-memory sources
//   bus                 data bus (master modport)
//   o_mem_stall         hold M and earlier stages
//   o_load_data         aligned, extended load result (registered)
//   o_addr_err_load     AdEL
//   o_addr_err_store    AdES
//   o_bad_vaddr         faulting address
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read_en,
    input  logic              i_mem_write_en,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [2:0]        i_ls_op,
    input  logic [31:0]       i_wdata_in,
    input  logic              i_flush,
    input  logic              i_stall_ext,
    mem_access_ctrl_if.master bus,
    output logic              o_mem_stall,
    output logic [31:0]       o_load_data,
    output logic              o_addr_err_load,
    output logic              o_addr_err_store,
    output logic [ADDR_W-1:0] o_bad_vaddr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ADDR,
        S_WAIT_DATA,
        S_DRAIN_ADDR,
        S_DRAIN_DATA,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_B  = 3'd0,
        OP_BU = 3'd1,
        OP_H  = 3'd2,
        OP_HU = 3'd3,
        OP_W  = 3'd4,
        OP_WL = 3'd5,
        OP_WR = 3'd6
    } ls_op_e;

    state_e            r_state;
    ls_op_e            r_op;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [31:0]       r_rt;
    logic [31:0]       r_load_data;

    ls_op_e            w_op;
    ls_op_e            w_src_op;
    logic [ADDR_W-1:0] w_src_addr;
    logic              w_src_wr;
    logic [31:0]       w_src_rt;
    logic              w_any;
    logic              w_adderr;
    logic              w_access;
    logic              w_issue;
    logic              w_req;
    logic [1:0]        w_size;
    logic [ADDR_W-1:0] w_bus_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wstrb;
    logic [7:0]        w_lbyte;
    logic [15:0]       w_lhalf;
    logic [31:0]       w_load_fmt;

    // Normalise the op so the rest of the logic only sees legal encodings;
    // without the unaligned feature, 5/6 collapse onto plain word accesses.
    // NOTE: every combinational output gets a default (here: the case default)
    // on every path, otherwise synthesis infers a latch.
    always_comb begin
        case (i_ls_op)
            3'd0:    w_op = OP_B;
            3'd1:    w_op = OP_BU;
            3'd2:    w_op = OP_H;
            3'd3:    w_op = OP_HU;
`ifdef UNALIGNED_LS_EN
            3'd5:    w_op = OP_WL;
            3'd6:    w_op = OP_WR;
`endif
            default: w_op = OP_W;
        endcase
    end

    always_comb begin
        case (w_op)
            OP_H, OP_HU: w_adderr = i_mem_addr[0];
            OP_W:        w_adderr = |i_mem_addr[1:0];
            default:     w_adderr = 1'b0;
        endcase
    end

    assign w_any    = i_mem_read_en | i_mem_write_en;
    assign w_access = w_any & ~i_flush & ~w_adderr;
    assign w_issue  = (r_state == S_IDLE) & w_access;
    assign w_req    = w_issue | (r_state == S_WAIT_ADDR) | (r_state == S_DRAIN_ADDR);

    assign o_addr_err_load  = w_adderr & i_mem_read_en;
    assign o_addr_err_store = w_adderr & i_mem_write_en;
    assign o_bad_vaddr      = (o_addr_err_load | o_addr_err_store) ? i_mem_addr : '0;

    // Request fields come straight from the pipeline while issuing, and from
    // the copy captured at issue once the request has left IDLE.
    assign w_src_op   = w_issue ? w_op           : r_op;
    assign w_src_addr = w_issue ? i_mem_addr     : r_addr;
    assign w_src_wr   = w_issue ? i_mem_write_en : r_wr;
    assign w_src_rt   = w_issue ? i_wdata_in     : r_rt;

    always_comb begin
        w_size     = 2'd2;
        w_bus_addr = w_src_addr;
        case (w_src_op)
            OP_B, OP_BU: w_size = 2'd0;
            OP_H, OP_HU: w_size = 2'd1;
`ifdef UNALIGNED_LS_EN
            OP_WL, OP_WR: w_bus_addr = {w_src_addr[ADDR_W-1:2], 2'b00};
`endif
            default:     w_size = 2'd2;
        endcase
    end

    always_comb begin
        w_wdata = w_src_rt;
        w_wstrb = 4'b1111;
        case (w_src_op)
            OP_B, OP_BU: begin
                w_wdata = {4{w_src_rt[7:0]}};
                w_wstrb = 4'b0001 << w_src_addr[1:0];
            end
            OP_H, OP_HU: begin
                w_wdata = {2{w_src_rt[15:0]}};
                w_wstrb = w_src_addr[1] ? 4'b1100 : 4'b0011;
            end
`ifdef UNALIGNED_LS_EN
            // SWL writes the rt bytes from the MSB down to the addressed byte.
            OP_WL: begin
                case (w_src_addr[1:0])
                    2'd0:    begin w_wdata = {24'd0, w_src_rt[31:24]}; w_wstrb = 4'b0001; end
                    2'd1:    begin w_wdata = {16'd0, w_src_rt[31:16]}; w_wstrb = 4'b0011; end
                    2'd2:    begin w_wdata = {8'd0,  w_src_rt[31:8]};  w_wstrb = 4'b0111; end
                    default: begin w_wdata = w_src_rt;                 w_wstrb = 4'b1111; end
                endcase
            end
            // SWR writes the rt bytes from the LSB up from the addressed byte.
            OP_WR: begin
                case (w_src_addr[1:0])
                    2'd0:    begin w_wdata = w_src_rt;                 w_wstrb = 4'b1111; end
                    2'd1:    begin w_wdata = {w_src_rt[23:0], 8'd0};  w_wstrb = 4'b1110; end
                    2'd2:    begin w_wdata = {w_src_rt[15:0], 16'd0}; w_wstrb = 4'b1100; end
                    default: begin w_wdata = {w_src_rt[7:0], 24'd0};  w_wstrb = 4'b1000; end
                endcase
            end
`endif
            default: begin
                w_wdata = w_src_rt;
                w_wstrb = 4'b1111;
            end
        endcase
    end

    // Strobes are only meaningful for writes; reads present none.
    assign bus.data_req   = w_req;
    assign bus.data_wr    = w_req & w_src_wr;
    assign bus.data_size  = w_req ? w_size : 2'd0;
    assign bus.data_addr  = w_req ? w_bus_addr : '0;
    assign bus.data_wdata = w_req ? w_wdata : 32'd0;
    assign bus.data_wstrb = (w_req & w_src_wr) ? w_wstrb : 4'd0;

    // Load lane selection uses the address captured at issue.
    assign w_lbyte = bus.data_rdata[{r_addr[1:0], 3'b000} +: 8];
    assign w_lhalf = r_addr[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];

    always_comb begin
        w_load_fmt = bus.data_rdata;
        case (r_op)
            OP_B:  w_load_fmt = {{24{w_lbyte[7]}}, w_lbyte};
            OP_BU: w_load_fmt = {24'd0, w_lbyte};
            OP_H:  w_load_fmt = {{16{w_lhalf[15]}}, w_lhalf};
            OP_HU: w_load_fmt = {16'd0, w_lhalf};
`ifdef UNALIGNED_LS_EN
            // LWL fills rt from the MSB down with memory bytes up to the address.
            OP_WL: begin
                case (r_addr[1:0])
                    2'd0:    w_load_fmt = {bus.data_rdata[7:0],  r_rt[23:0]};
                    2'd1:    w_load_fmt = {bus.data_rdata[15:0], r_rt[15:0]};
                    2'd2:    w_load_fmt = {bus.data_rdata[23:0], r_rt[7:0]};
                    default: w_load_fmt = bus.data_rdata;
                endcase
            end
            // LWR fills rt from the LSB up with memory bytes from the address.
            OP_WR: begin
                case (r_addr[1:0])
                    2'd0:    w_load_fmt = bus.data_rdata;
                    2'd1:    w_load_fmt = {r_rt[31:24], bus.data_rdata[31:8]};
                    2'd2:    w_load_fmt = {r_rt[31:16], bus.data_rdata[31:16]};
                    default: w_load_fmt = {r_rt[31:8],  bus.data_rdata[31:24]};
                endcase
            end
`endif
            default: w_load_fmt = bus.data_rdata;
        endcase
    end

    // Drain states only hold the pipeline if a new memory op is waiting for
    // the bus; DONE releases M so the pipeline can advance.
    always_comb begin
        case (r_state)
            S_IDLE:                     o_mem_stall = w_access;
            S_WAIT_ADDR, S_WAIT_DATA:   o_mem_stall = 1'b1;
            S_DRAIN_ADDR, S_DRAIN_DATA: o_mem_stall = w_any;
            default:                    o_mem_stall = 1'b0;
        endcase
    end

    assign o_load_data = r_load_data;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_B;
            r_addr      <= '0;
            r_wr        <= 1'b0;
            r_rt        <= 32'd0;
            r_load_data <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_op    <= w_op;
                        r_addr  <= i_mem_addr;
                        r_wr    <= i_mem_write_en;
                        r_rt    <= i_wdata_in;
                        r_state <= bus.data_addr_ok ? S_WAIT_DATA : S_WAIT_ADDR;
                    end
                end
                S_WAIT_ADDR: begin
                    if (bus.data_addr_ok) begin
                        r_state <= i_flush ? S_DRAIN_DATA : S_WAIT_DATA;
                    end else if (i_flush) begin
                        r_state <= S_DRAIN_ADDR;
                    end
                end
                S_WAIT_DATA: begin
                    if (i_flush) begin
                        r_state <= bus.data_data_ok ? S_IDLE : S_DRAIN_DATA;
                    end else if (bus.data_data_ok) begin
                        r_load_data <= w_load_fmt;
                        r_state     <= S_DONE;
                    end
                end
                S_DRAIN_ADDR: begin
                    if (bus.data_addr_ok) begin
                        r_state <= S_DRAIN_DATA;
                    end
                end
                S_DRAIN_DATA: begin
                    if (bus.data_data_ok) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (!i_stall_ext) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl. Stimulus pushes the expected bus
//   request and load result into queues; a monitor pops and compares them when
//   the controller hands a request to the bus or a load retires from M.
//   Build with +define+UNALIGNED_LS_EN to exercise the LWL/LWR/SWL/SWR cases.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic        clk;
    logic        rst;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [2:0]  ls_op;
    logic [31:0] wdata_in;
    logic        flush;
    logic        stall_ext;
    logic        mem_stall;
    logic [31:0] load_data;
    logic        addr_err_load;
    logic        addr_err_store;
    logic [31:0] bad_vaddr;

    mem_access_ctrl_if #(.ADDR_W(32)) bus ();

    mem_access_ctrl #(.ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_mem_read_en    (mem_read_en),
        .i_mem_write_en   (mem_write_en),
        .i_mem_addr       (mem_addr),
        .i_ls_op          (ls_op),
        .i_wdata_in       (wdata_in),
        .i_flush          (flush),
        .i_stall_ext      (stall_ext),
        .bus              (bus),
        .o_mem_stall      (mem_stall),
        .o_load_data      (load_data),
        .o_addr_err_load  (addr_err_load),
        .o_addr_err_store (addr_err_store),
        .o_bad_vaddr      (bad_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    req_t        exp_req[$];
    logic [31:0] exp_load[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic req_t mk_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wstrb);
        req_t r;
        r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata; r.wstrb = wstrb;
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read_en      = 1'b0;
        mem_write_en     = 1'b0;
        mem_addr         = 32'd0;
        ls_op            = 3'd0;
        wdata_in         = 32'd0;
        flush            = 1'b0;
        stall_ext        = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
    endtask

    // Monitor: a bus handshake pops an expected request; a load leaving M
    // (no stall of any kind, not flushed, no address error) pops a result.
    initial begin
        req_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.data_req && bus.data_addr_ok) begin
                    if (exp_req.size() == 0) begin
                        check("req_unexpected", 32'(bus.data_addr), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_req.pop_front();
                        check("req_wr",   32'(bus.data_wr),   32'(e.wr));
                        check("req_size", 32'(bus.data_size), 32'(e.size));
                        check("req_addr", bus.data_addr,      e.addr);
                        if (e.wr) begin
                            check("req_wdata", bus.data_wdata,      e.wdata);
                            check("req_wstrb", 32'(bus.data_wstrb), 32'(e.wstrb));
                        end
                    end
                end
                if (mem_read_en && !mem_stall && !stall_ext && !flush && !addr_err_load) begin
                    if (exp_load.size() == 0) begin
                        check("load_unexpected", load_data, 32'hDEAD_0000);
                    end else begin
                        check("load_data", load_data, exp_load.pop_front());
                    end
                end
            end
        end
    end

    // One complete access: addr_ok after addr_wait cycles, data_ok the cycle
    // after acceptance, then one DONE cycle with the pipeline free to advance.
    task automatic do_access(input logic is_wr, input logic [31:0] a, input logic [2:0] op,
                             input logic [31:0] rt, input int addr_wait, input logic [31:0] rdata,
                             input req_t exp_r, input logic [31:0] exp_ld);
        mem_read_en  = !is_wr;
        mem_write_en = is_wr;
        mem_addr     = a;
        ls_op        = op;
        wdata_in     = rt;
        exp_req.push_back(exp_r);
        for (int c = 0; c <= addr_wait; c++) begin
            bus.data_addr_ok = (c == addr_wait);
            @(negedge clk);
            check("req_held",       32'(bus.data_req), 32'd1);
            check("req_addr_const", bus.data_addr,     exp_r.addr);
            check("stall_addr",     32'(mem_stall),    32'd1);
            next_cycle();
        end
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b1;
        bus.data_rdata   = rdata;
        if (!is_wr) exp_load.push_back(exp_ld);
        @(negedge clk);
        check("stall_data", 32'(mem_stall),    32'd1);
        check("req_off",    32'(bus.data_req), 32'd0);
        next_cycle();
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'd0;
        @(negedge clk);
        check("stall_done", 32'(mem_stall), 32'd0);
        next_cycle();
        idle_inputs();
    endtask

    task automatic adderr_case(input logic is_wr, input logic [31:0] a, input logic [2:0] op);
        mem_read_en  = !is_wr;
        mem_write_en = is_wr;
        mem_addr     = a;
        ls_op        = op;
        @(negedge clk);
        check("adel",      32'(addr_err_load),  32'(!is_wr));
        check("ades",      32'(addr_err_store), 32'(is_wr));
        check("bad_vaddr", bad_vaddr,           a);
        check("err_noreq", 32'(bus.data_req),   32'd0);
        check("err_stall", 32'(mem_stall),      32'd0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("err_idle", 32'(bus.data_req), 32'd0);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (3) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_req",   32'(bus.data_req),      32'd0);
        check("rst_stall", 32'(mem_stall),         32'd0);
        check("rst_load",  load_data,              32'd0);
        check("rst_adel",  32'(addr_err_load),     32'd0);
        check("rst_ades",  32'(addr_err_store),    32'd0);
        check("rst_wstrb", 32'(bus.data_wstrb),    32'd0);
        next_cycle();

        // LB 0x1003, rdata 0x80FF_0000 -> byte 0x80 sign-extended.
        do_access(1'b0, 32'h0000_1003, 3'd0, 32'd0, 0, 32'h80FF_0000,
                  mk_req(1'b0, 2'd0, 32'h0000_1003, 32'd0, 4'd0), 32'hFFFF_FF80);
        // SH 0x2002, rt 0x1234_ABCD.
        do_access(1'b1, 32'h0000_2002, 3'd2, 32'h1234_ABCD, 0, 32'd0,
                  mk_req(1'b1, 2'd1, 32'h0000_2002, 32'hABCD_ABCD, 4'b1100), 32'd0);
        // SB 0x4001 and SW 0x5000.
        do_access(1'b1, 32'h0000_4001, 3'd0, 32'h0000_00A5, 1, 32'd0,
                  mk_req(1'b1, 2'd0, 32'h0000_4001, 32'hA5A5_A5A5, 4'b0010), 32'd0);
        do_access(1'b1, 32'h0000_5000, 3'd4, 32'hDEAD_BEEF, 0, 32'd0,
                  mk_req(1'b1, 2'd2, 32'h0000_5000, 32'hDEAD_BEEF, 4'b1111), 32'd0);
        // LHU 0x6002 with addr_ok delayed 3 cycles.
        do_access(1'b0, 32'h0000_6002, 3'd3, 32'd0, 3, 32'h8001_0000,
                  mk_req(1'b0, 2'd1, 32'h0000_6002, 32'd0, 4'd0), 32'h0000_8001);
        // LH 0x6000 sign extension from the low half, LW plain.
        do_access(1'b0, 32'h0000_6000, 3'd2, 32'd0, 0, 32'h0000_9ABC,
                  mk_req(1'b0, 2'd1, 32'h0000_6000, 32'd0, 4'd0), 32'hFFFF_9ABC);
        do_access(1'b0, 32'h0000_6004, 3'd7, 32'd0, 0, 32'h1357_9BDF,
                  mk_req(1'b0, 2'd2, 32'h0000_6004, 32'd0, 4'd0), 32'h1357_9BDF);

        // Address errors: no request, no stall.
        adderr_case(1'b0, 32'h0000_3001, 3'd4);
        adderr_case(1'b1, 32'h0000_3002, 3'd4);
        adderr_case(1'b0, 32'h0000_3001, 3'd3);

        // Flush in WAIT_DATA, then a new LW waits for the old data_ok.
        mem_read_en = 1'b1; mem_addr = 32'h0000_7000; ls_op = 3'd4; bus.data_addr_ok = 1'b1;
        exp_req.push_back(mk_req(1'b0, 2'd2, 32'h0000_7000, 32'd0, 4'd0));
        next_cycle();
        bus.data_addr_ok = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("fwd_stall_wait", 32'(mem_stall), 32'd1);
        next_cycle();
        flush = 1'b0; mem_addr = 32'h0000_7100;
        for (int c = 0; c < 3; c++) begin
            bus.data_data_ok = (c == 2);
            bus.data_rdata   = (c == 2) ? 32'hBAD0_BAD0 : 32'd0;
            @(negedge clk);
            check("fwd_drain_stall", 32'(mem_stall),    32'd1);
            check("fwd_drain_noreq", 32'(bus.data_req), 32'd0);
            next_cycle();
        end
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0; bus.data_addr_ok = 1'b1;
        exp_req.push_back(mk_req(1'b0, 2'd2, 32'h0000_7100, 32'd0, 4'd0));
        @(negedge clk);
        check("fwd_new_req", 32'(bus.data_req), 32'd1);
        next_cycle();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0C0F_FEE0;
        exp_load.push_back(32'h0C0F_FEE0);
        next_cycle();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
        @(negedge clk);
        check("fwd_done_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        idle_inputs();

        // Flush in WAIT_ADDR: the request stays up with its captured address.
        mem_read_en = 1'b1; mem_addr = 32'h0000_8000; ls_op = 3'd4;
        exp_req.push_back(mk_req(1'b0, 2'd2, 32'h0000_8000, 32'd0, 4'd0));
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        check("fwa_req", 32'(bus.data_req), 32'd1);
        next_cycle();
        flush = 1'b0; mem_read_en = 1'b0; mem_addr = 32'd0; bus.data_addr_ok = 1'b1;
        @(negedge clk);
        check("fwa_drain_req",   32'(bus.data_req), 32'd1);
        check("fwa_drain_addr",  bus.data_addr,     32'h0000_8000);
        check("fwa_drain_stall", 32'(mem_stall),    32'd0);
        next_cycle();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1;
        next_cycle();
        bus.data_data_ok = 1'b0;
        @(negedge clk);
        check("fwa_idle_req", 32'(bus.data_req), 32'd0);
        next_cycle();

        // Flush together with data_ok in WAIT_DATA: straight back to IDLE.
        mem_read_en = 1'b1; mem_addr = 32'h0000_9000; ls_op = 3'd4; bus.data_addr_ok = 1'b1;
        exp_req.push_back(mk_req(1'b0, 2'd2, 32'h0000_9000, 32'd0, 4'd0));
        next_cycle();
        bus.data_addr_ok = 1'b0; flush = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
        next_cycle();
        idle_inputs();
        do_access(1'b0, 32'h0000_9001, 3'd1, 32'd0, 0, 32'h0000_AB00,
                  mk_req(1'b0, 2'd0, 32'h0000_9001, 32'd0, 4'd0), 32'h0000_00AB);

        // DONE held by stall_ext for 2 cycles.
        mem_read_en = 1'b1; mem_addr = 32'h0000_A000; ls_op = 3'd2; bus.data_addr_ok = 1'b1;
        exp_req.push_back(mk_req(1'b0, 2'd1, 32'h0000_A000, 32'd0, 4'd0));
        next_cycle();
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_F00D;
        exp_load.push_back(32'hFFFF_F00D);
        next_cycle();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h5555_5555; stall_ext = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("done_hold_load",  load_data,         32'hFFFF_F00D);
            check("done_hold_stall", 32'(mem_stall),    32'd0);
            check("done_hold_noreq", 32'(bus.data_req), 32'd0);
            next_cycle();
        end
        stall_ext = 1'b0;
        next_cycle();
        idle_inputs();

`ifdef UNALIGNED_LS_EN
        do_access(1'b0, 32'h0000_B001, 3'd5, 32'hAABB_CCDD, 0, 32'h4433_2211,
                  mk_req(1'b0, 2'd2, 32'h0000_B000, 32'd0, 4'd0), 32'h2211_CCDD);
        do_access(1'b0, 32'h0000_B002, 3'd6, 32'hAABB_CCDD, 0, 32'h4433_2211,
                  mk_req(1'b0, 2'd2, 32'h0000_B000, 32'd0, 4'd0), 32'hAABB_4433);
        do_access(1'b1, 32'h0000_B000, 3'd5, 32'h1122_3344, 0, 32'd0,
                  mk_req(1'b1, 2'd2, 32'h0000_B000, 32'h0000_0011, 4'b0001), 32'd0);
        do_access(1'b1, 32'h0000_B002, 3'd6, 32'h1122_3344, 0, 32'd0,
                  mk_req(1'b1, 2'd2, 32'h0000_B000, 32'h3344_0000, 4'b1100), 32'd0);
`else
        adderr_case(1'b0, 32'h0000_B001, 3'd5);
        do_access(1'b1, 32'h0000_C000, 3'd6, 32'h1122_3344, 0, 32'd0,
                  mk_req(1'b1, 2'd2, 32'h0000_C000, 32'h1122_3344, 4'b1111), 32'd0);
`endif

        // Reset while waiting for addr_ok returns to IDLE and clears load_data.
        mem_read_en = 1'b1; mem_addr = 32'h0000_D000; ls_op = 3'd4;
        next_cycle();
        rst = 1'b1; mem_read_en = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req",   32'(bus.data_req), 32'd0);
        check("rst_mid_stall", 32'(mem_stall),    32'd0);
        check("rst_mid_load",  load_data,         32'd0);
        next_cycle();

        check("req_queue_empty",  32'(exp_req.size()),  32'd0);
        check("load_queue_empty", 32'(exp_load.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
